// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with next-PC select: reset > redirect load > sequential increment.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] target,
    input  logic        inc,
    output logic [31:0] pc
);

    // PC update; a redirect target is always word aligned before loading.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= align_word(target);
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one request at a time, presents the fetched
// instruction to IF/ID and handles branch/jump redirects and stalls.
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | request presented at PC, waiting for imem_ready
// WAIT  | request accepted, waiting for the read data
// DRAIN | request accepted but squashed; next rvalid is thrown away
// HOLD  | instruction presented to IF/ID, held while stall is high
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] PCplus4,
    output logic        inst_valid
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         redirect;
    logic [31:0]  redirect_target;
    logic         capture;
    logic         release_hold;
    logic [31:0]  pc;

    assign redirect        = branch_taken | jump;
    assign redirect_target = branch_taken ? branch_target : jump_target;
    assign imem_addr       = pc;

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clock  (clock),
        .reset  (reset),
        .load   (redirect),
        .target (redirect_target),
        .inc    (capture),
        .pc     (pc)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. A redirect arriving together with the drained
    // response in DRAIN finishes the drain, otherwise nothing would ever
    // release the FSM from DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_REQ: begin
                if (imem_ready) begin
                    state_nxt = redirect ? ST_DRAIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = redirect ? ST_REQ : ST_HOLD;
                end else if (redirect) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect || !stall) begin
                    state_nxt = ST_REQ;
                end
            end
            default: state_nxt = ST_REQ;
        endcase
    end

    // Output decode: request strobe plus capture/release strobes for IF/ID.
    always_comb begin
        imem_req     = (state == ST_REQ) && !reset;
        capture      = (state == ST_WAIT) && imem_rvalid && !redirect;
        release_hold = (state == ST_HOLD) && !stall;
    end

    // IF/ID register; imem_rdata only reaches outputs through these flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            inst       <= NOP;
            PCplus4    <= 32'd0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            inst       <= NOP;
            inst_valid <= 1'b0;
        end else if (capture) begin
            inst       <= imem_rdata;
            PCplus4    <= pc + 32'd4;
            inst_valid <= 1'b1;
        end else if (release_hold) begin
            inst       <= NOP;
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all compared every cycle against a transaction-level model.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] PCplus4;
    logic        inst_valid;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Model: PC, whether a request is outstanding, whether its response is
    // to be thrown away, and whether an instruction sits in IF/ID.
    logic [31:0] m_pc;
    logic        m_pending;
    logic        m_discard;
    logic        m_holding;
    logic [31:0] m_inst;
    logic [31:0] m_p4;
    logic        m_valid;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .inst          (inst),
        .PCplus4       (PCplus4),
        .inst_valid    (inst_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // request outputs, then advance the model across the rising edge.
    task automatic step(input bit rst, input bit st,
                        input bit bt, input logic [31:0] bta,
                        input bit jp, input logic [31:0] jta,
                        input bit rdy, input bit rv, input logic [31:0] rd);
        logic        redir;
        logic [31:0] tgt;
        @(negedge clock);
        check("inst", inst, m_inst);
        check("PCplus4", PCplus4, m_p4);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        reset = rst; stall = st;
        branch_taken = bt; branch_target = bta;
        jump = jp; jump_target = jta;
        imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
        #1;
        check("imem_req", {31'd0, imem_req},
              {31'd0, (!rst && !m_pending && !m_holding)});
        check("imem_addr", imem_addr, m_pc);

        if (rst) begin
            m_pc = 32'h0; m_pending = 0; m_discard = 0; m_holding = 0;
            m_inst = 32'h0; m_p4 = 32'h0; m_valid = 0;
        end else begin
            redir = bt | jp;
            tgt = bt ? bta : jta;
            tgt = tgt & 32'hFFFF_FFFC;
            if (m_holding) begin
                if (redir || !st) begin
                    m_holding = 0; m_inst = 32'h0; m_valid = 0;
                end
            end else if (m_pending) begin
                if (rv) begin
                    m_pending = 0;
                    if (!m_discard && !redir) begin
                        m_inst = rd; m_p4 = m_pc + 32'd4; m_valid = 1;
                        m_pc = m_pc + 32'd4; m_holding = 1;
                    end
                end else if (redir) begin
                    m_discard = 1;
                end
            end else if (rdy) begin
                m_pending = 1;
                m_discard = redir;
            end
            if (redir) begin
                m_pc = tgt; m_inst = 32'h0; m_valid = 0;
            end
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] tb, tj;
        m_pc = 32'h0; m_pending = 0; m_discard = 0; m_holding = 0;
        m_inst = 32'h0; m_p4 = 32'h0; m_valid = 0;
        reset = 1; stall = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_target = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        @(posedge clock);

        // Reset, then basic fetch stream at 0, 4, 8.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 32'h2008_0005);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 32'h2008_0005);

        // Stall for three cycles in HOLD.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA_0001);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 1, 1, 32'hBBBB_0002);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Redirect in WAIT with the response two cycles later.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 32'h40, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 32'h1111_2222);

        // Branch and jump together: branch wins.
        step(0, 0, 1, 32'h80, 1, 32'h100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Misaligned jump target and fetch at the top of the address space.
        step(0, 0, 0, 0, 1, 32'h43, 0, 0, 0);
        step(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 32'h3333_4444);

        // Reset in WAIT, stale rvalid after reset falls.
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_6666);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1, 1, 32'h7777_8888);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom;
            tb = (r[20:19] == 2'b00) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            tj = $urandom;
            step((r[5:0] == 6'd0), r[6],
                 (r[10:7] == 4'd0), tb,
                 (r[14:11] == 4'd0), tj,
                 (r[16:15] != 2'b00), r[17], $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
